// File: rtl/cache_arb_pkg.sv
// ----------------------------------------------------------------------------
// cache_arb_pkg
// Shared definitions for the data-cache port arbiter:
//   - arb_state_t : IDLE / ISSUE / WAIT sequencing of one cache access
//   - owner_t     : which requester owns the access in flight (IF or MEM)
//   - owner_is_mem: small decode helper used by the datapath
// ----------------------------------------------------------------------------
package cache_arb_pkg;

    // One cache access: grant in IDLE, strobe c_valid in ISSUE, wait for the
    // cache's output-valid in WAIT.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    // Requester that owns the current (or most recent) cache access.
    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    function automatic logic owner_is_mem(input owner_t owner);
        return (owner == OWNER_MEM) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter_if
// Bundles the requester-side (IF, MEM) and cache-side handshakes of the shared
// data-cache port.
//   modport slave  : the arbiter's view (takes requests, drives the cache)
//   modport master : the environment's view (requesters plus cache)
// Signals:
//   if_req/if_addr -> if_done/if_rdata                 instruction-fetch reads
//   mem_req/mem_rw/mem_addr/mem_wdata -> mem_done/mem_rdata  MEM-stage access
//   stall                                              pipeline stall
//   c_valid/c_addr/c_rw/c_din -> cache; c_ready/c_out_valid/c_dout/c_hit <- cache
// ----------------------------------------------------------------------------
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    logic              c_valid;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rw;
    logic [DATA_W-1:0] c_din;
    logic              c_ready;
    logic              c_out_valid;
    logic [DATA_W-1:0] c_dout;
    logic              c_hit;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_rdata,
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_done, mem_rdata,
        output stall,
        output c_valid, c_addr, c_rw, c_din,
        input  c_ready, c_out_valid, c_dout, c_hit
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_rdata,
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_done, mem_rdata,
        input  stall,
        input  c_valid, c_addr, c_rw, c_din,
        output c_ready, c_out_valid, c_dout, c_hit
    );

endinterface

// File: rtl/cache_port_arbiter_prio_sel.sv
// ----------------------------------------------------------------------------
// arb_priority_sel
// Picks the winner of the shared cache port. MEM has priority; IF is forced
// through once it has lost STARVE_LIMIT consecutive arbitrations.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   if_req_i        IF is competing this cycle
//   mem_req_i       MEM is competing this cycle
//   grant_en_i      a grant is actually taken this cycle (updates starve count)
//   winner_o        combinational winner for this cycle
// ----------------------------------------------------------------------------
module arb_priority_sel
    import cache_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req_i,
    input  logic   mem_req_i,
    input  logic   grant_en_i,
    output owner_t winner_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             if_starved_s;
    owner_t           winner_s;

    // Winner select: MEM wins unless a requesting IF has hit the starvation limit.
    always_comb begin
        if_starved_s = if_req_i && (starve_cnt_q == LIMIT_C);
        winner_s     = OWNER_IF;
        if (mem_req_i && !if_starved_s) begin
            winner_s = OWNER_MEM;
        end else begin
            winner_s = OWNER_IF;
        end
    end

    // Starvation count: only moves on a real grant; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!grant_en_i) begin
            starve_cnt_d = starve_cnt_q;
        end else if (winner_s == OWNER_IF) begin
            starve_cnt_d = ZERO_C;
        end else if (if_req_i && (starve_cnt_q < LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + ONE_C;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= ZERO_C;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign winner_o = winner_s;

endmodule

// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
// Shares the single data-cache port between the IF and MEM requesters of the
// pipeline. One access at a time: grant in IDLE (needs c_ready), one-cycle
// c_valid strobe in ISSUE, wait for c_out_valid in WAIT, then a one-cycle done
// pulse with registered read data to the owner.
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   bus          cache_port_arbiter_if.slave (requester + cache handshakes)
//   stat_hits    hit counter   (only with CACHE_STATS_EN)
//   stat_misses  miss counter  (only with CACHE_STATS_EN)
// Build option:
//   CACHE_STATS_EN  adds wrapping hit/miss counters of width STATS_W.
// ----------------------------------------------------------------------------
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef CACHE_STATS_EN
    ,
    parameter int STATS_W      = 32
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    cache_port_arbiter_if.slave     bus
`ifdef CACHE_STATS_EN
    ,
    output logic [STATS_W-1:0]      stat_hits,
    output logic [STATS_W-1:0]      stat_misses
`endif
);

    arb_state_t        state_q,     state_d;
    owner_t            owner_q,     owner_d;
    logic              c_valid_q,   c_valid_d;
    logic [ADDR_W-1:0] c_addr_q,    c_addr_d;
    logic              c_rw_q,      c_rw_d;
    logic [DATA_W-1:0] c_din_q,     c_din_d;
    logic              if_done_q,   if_done_d;
    logic              mem_done_q,  mem_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic              if_req_s;
    logic              mem_req_s;
    logic              grant_en_s;
    owner_t            winner_s;

    // A requester that is receiving its done pulse still holds req this cycle
    // for the access that just finished; mask it so it is not granted twice.
    always_comb begin
        if_req_s   = bus.if_req  & ~if_done_q;
        mem_req_s  = bus.mem_req & ~mem_done_q;
        grant_en_s = (state_q == ST_IDLE) && bus.c_ready && (if_req_s || mem_req_s);
    end

    arb_priority_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_sel (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (if_req_s),
        .mem_req_i  (mem_req_s),
        .grant_en_i (grant_en_s),
        .winner_o   (winner_s)
    );

    // Next-state and datapath updates of the access sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        c_valid_d   = 1'b0;
        c_addr_d    = c_addr_q;
        c_rw_d      = c_rw_q;
        c_din_d     = c_din_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_en_s) begin
                    state_d   = ST_ISSUE;
                    owner_d   = winner_s;
                    c_valid_d = 1'b1;
                    if (winner_s == OWNER_MEM) begin
                        c_addr_d = bus.mem_addr;
                        c_rw_d   = bus.mem_rw;
                        c_din_d  = bus.mem_wdata;
                    end else begin
                        c_addr_d = bus.if_addr;
                        c_rw_d   = 1'b0;
                        c_din_d  = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // c_valid is a single-cycle strobe; fields stay latched.
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.c_out_valid) begin
                    state_d = ST_IDLE;
                    if (owner_is_mem(owner_q)) begin
                        mem_done_d = 1'b1;
                        if (!c_rw_q) begin
                            mem_rdata_d = bus.c_dout;
                        end else begin
                            mem_rdata_d = mem_rdata_q;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.c_dout;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                c_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            c_valid_q   <= 1'b0;
            c_addr_q    <= {ADDR_W{1'b0}};
            c_rw_q      <= 1'b0;
            c_din_q     <= {DATA_W{1'b0}};
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            mem_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            c_valid_q   <= c_valid_d;
            c_addr_q    <= c_addr_d;
            c_rw_q      <= c_rw_d;
            c_din_q     <= c_din_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.c_valid   = c_valid_q;
    assign bus.c_addr    = c_addr_q;
    assign bus.c_rw      = c_rw_q;
    assign bus.c_din     = c_din_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.mem_rdata = mem_rdata_q;

    // Stall must drop in the done cycle itself so the pipeline can advance.
    assign bus.stall = (bus.if_req & ~if_done_q) | (bus.mem_req & ~mem_done_q);

`ifdef CACHE_STATS_EN
    localparam logic [STATS_W-1:0] STAT_ONE_C  = STATS_W'(1);
    localparam logic [STATS_W-1:0] STAT_ZERO_C = {STATS_W{1'b0}};

    logic [STATS_W-1:0] stat_hits_q;
    logic [STATS_W-1:0] stat_misses_q;

    // Hit/miss counters, classified by c_hit on every cache completion; wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits_q   <= STAT_ZERO_C;
            stat_misses_q <= STAT_ZERO_C;
        end else if (bus.c_out_valid) begin
            if (bus.c_hit) begin
                stat_hits_q <= stat_hits_q + STAT_ONE_C;
            end else begin
                stat_misses_q <= stat_misses_q + STAT_ONE_C;
            end
        end else begin
            stat_hits_q   <= stat_hits_q;
            stat_misses_q <= stat_misses_q;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_port_arbiter
// Directed bench for cache_port_arbiter. Inputs change and outputs are
// sampled on the falling clock edge; a small cache model in serve() answers
// each c_valid strobe after a chosen latency.
// ----------------------------------------------------------------------------
module tb_cache_port_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    cache_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int          chk_cnt;
    int          fail_cnt;
    int          exp_hits;
    int          exp_misses;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cache model: wait for c_valid, check the latched fields, answer after lat cycles.
    // Returns on the falling edge where the owner's done pulse should be visible.
    task automatic serve(input string tag, input logic [31:0] dout, input logic hit,
                         input int lat, input bit gap, input logic [31:0] exp_addr,
                         input logic exp_rw, input logic [31:0] exp_din);
        int n;
        n = 0;
        while (bus.c_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_c_valid"}, bus.c_valid, 1);
        check_val({tag, "_c_addr"}, bus.c_addr, exp_addr);
        check_val({tag, "_c_rw"}, bus.c_rw, exp_rw);
        if (exp_rw) check_val({tag, "_c_din"}, bus.c_din, exp_din);
        @(negedge clk);
        check_val({tag, "_c_valid_one_cycle"}, bus.c_valid, 0);
        for (int k = 1; k < lat; k++) @(negedge clk);
        check_val({tag, "_stall_wait"}, bus.stall, 1);
        check_val({tag, "_c_addr_hold"}, bus.c_addr, exp_addr);
        bus.c_out_valid = 1'b1;
        bus.c_dout      = dout;
        bus.c_hit       = hit;
        if (gap) bus.c_ready = 1'b0;
        if (bus.c_hit) exp_hits++;
        else exp_misses++;
        @(negedge clk);
        bus.c_out_valid = 1'b0;
        bus.c_hit       = 1'b0;
    endtask

    task automatic check_done(input string tag, input bit exp_if, input bit exp_mem, input bit exp_stall);
        check_val({tag, "_if_done"}, bus.if_done, exp_if);
        check_val({tag, "_mem_done"}, bus.mem_done, exp_mem);
        check_val({tag, "_if_rdata"}, bus.if_rdata, exp_if_rdata);
        check_val({tag, "_mem_rdata"}, bus.mem_rdata, exp_mem_rdata);
        check_val({tag, "_stall"}, bus.stall, exp_stall);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          n;
        int          busy_valids;
        bit          mem_turn;
        logic [31:0] dv;
        logic [4:0]  hit_pat;

        chk_cnt       = 0;
        fail_cnt      = 0;
        exp_hits      = 0;
        exp_misses    = 0;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
        bus.if_req      = 1'b0;
        bus.if_addr     = 32'h0;
        bus.mem_req     = 1'b0;
        bus.mem_rw      = 1'b0;
        bus.mem_addr    = 32'h0;
        bus.mem_wdata   = 32'h0;
        bus.c_ready     = 1'b0;
        bus.c_out_valid = 1'b0;
        bus.c_dout      = 32'h0;
        bus.c_hit       = 1'b0;
        reset           = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_c_valid", bus.c_valid, 0);
        check_val("rst_c_addr", bus.c_addr, 0);
        check_val("rst_c_rw", bus.c_rw, 0);
        check_val("rst_c_din", bus.c_din, 0);
        check_done("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // 1: single IF read, cache answers 5 cycles after c_valid
        bus.c_ready = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        #1 check_val("t1_stall_req", bus.stall, 1);
        @(negedge clk);
        check_val("t1_grant_latency", bus.c_valid, 1);
        serve("t1", 32'hDEADBEEF, 1'b1, 5, 1'b0, 32'h40, 1'b0, 32'h0);
        exp_if_rdata = 32'hDEADBEEF;
        check_done("t1_done", 1'b1, 1'b0, 1'b0);
        bus.if_req = 1'b0;
        @(negedge clk);
        check_done("t1_after", 1'b0, 1'b0, 1'b0);
        check_val("t1_no_regrant", bus.c_valid, 0);

        // 2: IF and MEM both held; cache busy in each done cycle, so IF starves
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h200;
        bus.mem_req  = 1'b1;
        bus.mem_rw   = 1'b0;
        bus.mem_addr = 32'h80;
        for (int i = 0; i < 10; i++) begin
            mem_turn = ((i % 5) != 4);
            dv       = 32'hA000_0000 + 32'(i);
            serve("t2", dv, (i % 2 == 1), 1, 1'b1, mem_turn ? 32'h80 : 32'h200, 1'b0, 32'h0);
            if (mem_turn) exp_mem_rdata = dv;
            else exp_if_rdata = dv;
            check_done("t2_done", !mem_turn, mem_turn, 1'b1);
            if (i == 9) begin
                bus.if_req  = 1'b0;
                bus.mem_req = 1'b0;
            end
            @(negedge clk);
            bus.c_ready = 1'b1;
        end

        // 3: MEM write leaves mem_rdata untouched
        bus.mem_req   = 1'b1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = 32'h100;
        bus.mem_wdata = 32'h12345678;
        serve("t3", 32'hBAD0BAD0, 1'b1, 2, 1'b0, 32'h100, 1'b1, 32'h12345678);
        check_done("t3_done", 1'b0, 1'b1, 1'b0);
        bus.mem_req = 1'b0;
        bus.mem_rw  = 1'b0;
        @(negedge clk);
        check_done("t3_after", 1'b0, 1'b0, 1'b0);

        // 4: cache not ready for 10 cycles, then c_valid one cycle after ready
        bus.c_ready = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        busy_valids = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.c_valid) busy_valids++;
        end
        check_val("t4_no_c_valid_busy", busy_valids, 0);
        check_val("t4_stall_busy", bus.stall, 1);
        bus.c_ready = 1'b1;
        @(negedge clk);
        check_val("t4_c_valid_after_ready", bus.c_valid, 1);
        serve("t4", 32'h0BADF00D, 1'b0, 3, 1'b0, 32'h44, 1'b0, 32'h0);
        exp_if_rdata = 32'h0BADF00D;
        check_done("t4_done", 1'b1, 1'b0, 1'b0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // 5: reset during WAIT, then a fresh access
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h48;
        n = 0;
        while (bus.c_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_c_valid", bus.c_valid, 1);
        @(negedge clk);
        reset      = 1'b0;
        bus.if_req = 1'b0;
        #1;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
        exp_hits      = 0;
        exp_misses    = 0;
        check_val("t5_rst_c_valid", bus.c_valid, 0);
        check_val("t5_rst_c_addr", bus.c_addr, 0);
        check_done("t5_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4C;
        serve("t5", 32'hCAFEF00D, 1'b1, 2, 1'b0, 32'h4C, 1'b0, 32'h0);
        exp_if_rdata = 32'hCAFEF00D;
        check_done("t5_done", 1'b1, 1'b0, 1'b0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // 6: fresh reset, then 3 hits and 2 misses
        reset = 1'b0;
        @(negedge clk);
        reset         = 1'b1;
        exp_if_rdata  = 32'h0;
        exp_mem_rdata = 32'h0;
        exp_hits      = 0;
        exp_misses    = 0;
        hit_pat       = 5'b01101;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h500 + 32'(4 * i);
            dv          = 32'h5000_0000 + 32'(i);
            serve("t6", dv, hit_pat[i], 1, 1'b0, 32'h500 + 32'(4 * i), 1'b0, 32'h0);
            exp_if_rdata = dv;
            check_done("t6_done", 1'b1, 1'b0, 1'b0);
            bus.if_req = 1'b0;
            @(negedge clk);
        end
`ifdef CACHE_STATS_EN
        check_val("t6_stat_hits", stat_hits, 32'(exp_hits));
        check_val("t6_stat_misses", stat_misses, 32'(exp_misses));
        check_val("t6_stat_hits_abs", stat_hits, 3);
        check_val("t6_stat_misses_abs", stat_misses, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
